// File: rtl/exec_mdu_pkg.sv
// Shared definitions for the swt16 execute stage: op codes, branch
// conditions, iterative MDU state encoding and the MDU-op predicate.
package exec_mdu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_SLL   = 4'd2;
  localparam logic [OP_W-1:0] OP_SRL   = 4'd3;
  localparam logic [OP_W-1:0] OP_SRA   = 4'd4;
  localparam logic [OP_W-1:0] OP_AND   = 4'd5;
  localparam logic [OP_W-1:0] OP_OR    = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
  localparam logic [OP_W-1:0] OP_PASS2 = 4'd8;
  localparam logic [OP_W-1:0] OP_MULL  = 4'd9;
  localparam logic [OP_W-1:0] OP_MULH  = 4'd10;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd11;
  localparam logic [OP_W-1:0] OP_REMU  = 4'd12;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ0  = 2'd1;
  localparam logic [1:0] BR_GT0  = 2'd2;
  localparam logic [1:0] BR_LT0  = 2'd3;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
    return (op == OP_MULL) || (op == OP_MULH) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exec_mdu_iter.sv
// Iterative unsigned multiply / divide unit. One shift-add (MUL) or
// restoring-subtract (DIV) step per BUSY cycle, W steps per operation.
// acc holds the product high half / partial remainder, mq holds the
// multiplier shifting out / quotient shifting in.
module exec_mdu_iter
  import exec_mdu_pkg::*;
#(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int OP_WIDTH        = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [OP_WIDTH-1:0]        op,
  input  logic [IALU_WORD_WIDTH-1:0] a,
  input  logic [IALU_WORD_WIDTH-1:0] b,
  output logic                       busy,
  output logic                       done,
  output logic [IALU_WORD_WIDTH-1:0] res
);

  localparam int W     = IALU_WORD_WIDTH;
  localparam int CNT_W = $clog2(W);

  mdu_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [OP_WIDTH-1:0] op_p1;
  logic [W-1:0]        acc_p1;
  logic [W-1:0]        mq_p1;
  logic [W-1:0]        b_p1;
  logic [W:0]          sum;
  logic [W:0]          trial;
  logic                is_mul;

  assign is_mul = (op_p1 == OP_MULL) || (op_p1 == OP_MULH);
  // Carry out of the add lands in the top bit and is shifted into acc.
  assign sum    = {1'b0, acc_p1} + (mq_p1[0] ? {1'b0, b_p1} : '0);
  // Top bit set means the trial subtraction borrowed: restore.
  assign trial  = {acc_p1, mq_p1[W-1]} - {1'b0, b_p1};

  assign busy = (state == MDU_BUSY);
  assign done = (state == MDU_DONE);
  assign res  = ((op_p1 == OP_MULL) || (op_p1 == OP_DIVU)) ? mq_p1 : acc_p1;

  // Sequencer: IDLE -> BUSY for W steps -> DONE for one cycle -> IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MDU_IDLE: if (start) begin
          state <= MDU_BUSY;
          cnt   <= CNT_W'(W - 1);
        end
        MDU_BUSY: begin
          if (cnt == '0) state <= MDU_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        MDU_DONE: state <= MDU_IDLE;
        default:  state <= MDU_IDLE;
      endcase
    end
  end

  // Datapath: operand capture on start, then one iteration per BUSY cycle.
  // Divide by zero needs no special case: every trial succeeds, giving an
  // all-ones quotient and the dividend as remainder.
  always_ff @(posedge clock) begin
    if ((state == MDU_IDLE) && start) begin
      op_p1  <= op;
      acc_p1 <= '0;
      mq_p1  <= a;
      b_p1   <= b;
    end else if (state == MDU_BUSY) begin
      if (is_mul) begin
        {acc_p1, mq_p1} <= {sum, mq_p1[W-1:1]};
      end else if (!trial[W]) begin
        acc_p1 <= trial[W-1:0];
        mq_p1  <= {mq_p1[W-2:0], 1'b1};
      end else begin
        acc_p1 <= {acc_p1[W-2:0], mq_p1[W-1]};
        mq_p1  <= {mq_p1[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/exec_mdu.sv
// swt16 execute stage: single-cycle ALU, branch/jump resolution,
// load/store address generation and an iterative multiply/divide unit
// that stalls upstream while it works.
module exec_mdu
  import exec_mdu_pkg::*;
#(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int PC_WIDTH        = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int OP_WIDTH        = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [OP_WIDTH-1:0]        in_op,
  input  logic [1:0]                 in_br_cond,
  input  logic                       in_jump,
  input  logic                       in_flush,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic [IALU_WORD_WIDTH-1:0] in_src1,
  input  logic [IALU_WORD_WIDTH-1:0] in_src2,
  input  logic [IALU_WORD_WIDTH-1:0] in_src3,
  output logic                       out_stall,
  output logic                       out_valid,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic                       out_act_load_dmem,
  output logic                       out_act_store_dmem,
  output logic                       out_act_write_res_to_reg,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
  output logic [IALU_WORD_WIDTH-1:0] out_dmem_wr_word,
  output logic                       out_set_pc,
  output logic                       out_flush,
  output logic [PC_WIDTH-1:0]        out_branch_pc,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx
);

  localparam int W    = IALU_WORD_WIDTH;
  localparam int SH_W = $clog2(W);

  logic [OP_WIDTH-1:0]        op_p0;
  logic [1:0]                 br_p0;
  logic                       jump_p0, vld_p0, ld_p0, st_p0, wr_p0;
  logic [PMEM_WORD_WIDTH-1:0] instr_p0;
  logic [PC_WIDTH-1:0]        pc_p0;
  logic [REG_IDX_WIDTH-1:0]   idx_p0;
  logic signed [W-1:0]        src1_p0;
  logic [W-1:0]               src2_p0, src3_p0;

  logic [SH_W-1:0]     sh_amt;
  logic [W-1:0]        alu_res, res, mdu_res;
  logic signed [W-1:0] diff;
  logic                is_mdu, mdu_start, mdu_busy, mdu_done, taken;

  function automatic logic br_taken(input logic [1:0] cond, input logic signed [W-1:0] d);
    case (cond)
      BR_EQ0:  return d == '0;
      BR_GT0:  return !d[W-1] && (d != '0);
      BR_LT0:  return d[W-1];
      default: return 1'b0;
    endcase
  endfunction

  // Stage input registers: load whenever not stalled; a cleared valid marks a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_p0 <= '0; br_p0 <= '0; jump_p0 <= 1'b0; vld_p0 <= 1'b0;
      ld_p0 <= 1'b0; st_p0 <= 1'b0; wr_p0 <= 1'b0;
      instr_p0 <= '0; pc_p0 <= '0; idx_p0 <= '0;
      src1_p0 <= '0; src2_p0 <= '0; src3_p0 <= '0;
    end else if (!out_stall) begin
      op_p0 <= in_op; br_p0 <= in_br_cond; jump_p0 <= in_jump; vld_p0 <= !in_flush;
      ld_p0 <= in_act_load_dmem; st_p0 <= in_act_store_dmem; wr_p0 <= in_act_write_res_to_reg;
      instr_p0 <= in_instr; pc_p0 <= in_pc; idx_p0 <= in_res_reg_idx;
      src1_p0 <= in_src1; src2_p0 <= in_src2; src3_p0 <= in_src3;
    end
  end

  assign is_mdu    = is_mdu_op(op_p0);
  // Only start from IDLE; in DONE the same op is still in the registers.
  assign mdu_start = vld_p0 && is_mdu && !mdu_busy && !mdu_done;
  assign out_stall = mdu_start || mdu_busy;
  assign out_valid = vld_p0 && (!is_mdu || mdu_done);
  assign sh_amt    = src2_p0[SH_W-1:0];
  assign diff      = src1_p0 - src2_p0;

  exec_mdu_iter #(
    .IALU_WORD_WIDTH (W),
    .OP_WIDTH        (OP_WIDTH)
  ) u_iter (
    .clock (clock),
    .reset (reset),
    .start (mdu_start),
    .op    (op_p0),
    .a     (src1_p0),
    .b     (src2_p0),
    .busy  (mdu_busy),
    .done  (mdu_done),
    .res   (mdu_res)
  );

  // Single-cycle ALU on the registered operands.
  always_comb begin
    alu_res = '0;
    case (op_p0)
      OP_ADD:   alu_res = src1_p0 + src2_p0;
      OP_SUB:   alu_res = diff;
      OP_SLL:   alu_res = src1_p0 << sh_amt;
      OP_SRL:   alu_res = $unsigned(src1_p0) >> sh_amt;
      OP_SRA:   alu_res = src1_p0 >>> sh_amt;
      OP_AND:   alu_res = src1_p0 & src2_p0;
      OP_OR:    alu_res = src1_p0 | src2_p0;
      OP_XOR:   alu_res = src1_p0 ^ src2_p0;
      OP_PASS2: alu_res = src2_p0;
      default:  alu_res = '0;
    endcase
  end

  // Output muxing; everything is forced to zero unless this cycle is valid.
  // A branch/jump paired with an MDU op is ignored.
  always_comb begin
    res                      = is_mdu ? mdu_res : alu_res;
    taken                    = !is_mdu && (jump_p0 || br_taken(br_p0, diff));
    out_res                  = '0;
    out_act_load_dmem        = 1'b0;
    out_act_store_dmem       = 1'b0;
    out_act_write_res_to_reg = 1'b0;
    out_dmem_addr            = '0;
    out_dmem_wr_word         = '0;
    out_set_pc               = 1'b0;
    out_flush                = 1'b0;
    out_branch_pc            = '0;
    out_instr                = '0;
    out_pc                   = '0;
    out_res_reg_idx          = '0;
    if (out_valid) begin
      out_res                  = res;
      out_act_load_dmem        = ld_p0;
      out_act_store_dmem       = st_p0;
      out_act_write_res_to_reg = wr_p0;
      if (ld_p0 || st_p0) out_dmem_addr = res[DMEM_ADDR_WIDTH-1:0];
      if (st_p0)          out_dmem_wr_word = src3_p0;
      out_set_pc               = taken;
      out_flush                = taken;
      if (taken)          out_branch_pc = src3_p0[PC_WIDTH-1:0];
      out_instr                = instr_p0;
      out_pc                   = pc_p0;
      out_res_reg_idx          = idx_p0;
    end
  end

endmodule
